// File: rtl/run_monitor_pkg.sv
// Shared types for the run monitor: FSM states, termination causes and the
// registered result record.
package run_monitor_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CAUSE_W = 3;
    localparam int unsigned EXIT_W  = DATA_W - 1;

    typedef enum logic [1:0] {
        RM_IDLE = 2'd0,
        RM_RUN  = 2'd1,
        RM_DONE = 2'd2
    } rm_state_e;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_ECALL   = 3'd1,
        CAUSE_EBREAK  = 3'd2,
        CAUSE_TOHOST  = 3'd3,
        CAUSE_TIMEOUT = 3'd4
    } rm_cause_e;

    typedef struct packed {
        logic              done;
        logic              pass;
        rm_cause_e         cause;
        logic [EXIT_W-1:0] exit_code;
    } rm_result_t;

    localparam rm_result_t RESULT_RST = '{
        done:      1'b0,
        pass:      1'b0,
        cause:     CAUSE_NONE,
        exit_code: '0
    };

    // A store only ends the run when it hits the exit register with bit 0 set.
    function automatic logic tohost_hit(
        input logic              mem_write,
        input logic [ADDR_W-1:0] adr,
        input logic [DATA_W-1:0] data,
        input logic [ADDR_W-1:0] tohost_addr
    );
        return mem_write && (adr == tohost_addr) && data[0];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter
    import run_monitor_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_monitor.sv
// Watches a core for the end of a test run (tohost store, EBREAK, ECALL or
// watchdog) and latches a sticky, registered verdict plus run statistics.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              Ecall,
    input  logic              Ebreak,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic              done,
    output logic              pass,
    output logic [2:0]        cause,
    output logic [30:0]       exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  store_count
);

    // Compare in 64 bits so a watchdog limit wider than CNT_W never aliases.
    localparam logic [63:0] TIMEOUT_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    rm_state_e  state_q;
    rm_state_e  state_d;
    rm_result_t res_q;
    rm_result_t res_d;

    logic              running;
    logic              ev_tohost;
    logic              ev_timeout;
    logic [EXIT_W-1:0] store_code;

    assign running    = (state_q == RM_RUN);
    assign ev_tohost  = tohost_hit(MemWrite, DataAdr, WriteData, TOHOST_ADDR);
    assign ev_timeout = TIMEOUT_EN && (64'(cycle_count) == TIMEOUT_LAST);
    assign store_code = WriteData[DATA_W-1:1];

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        case (state_q)
            RM_IDLE: begin
                if (en) begin
                    state_d = RM_RUN;
                end
            end
            RM_RUN: begin
                // Priority chain: only the highest-ranked event is recorded.
                if (ev_tohost) begin
                    state_d         = RM_DONE;
                    res_d.done      = 1'b1;
                    res_d.cause     = CAUSE_TOHOST;
                    res_d.exit_code = store_code;
                    res_d.pass      = (store_code == '0);
                end else if (Ebreak) begin
                    state_d         = RM_DONE;
                    res_d.done      = 1'b1;
                    res_d.cause     = CAUSE_EBREAK;
                    res_d.exit_code = '0;
                    res_d.pass      = 1'b0;
                end else if (Ecall) begin
                    state_d         = RM_DONE;
                    res_d.done      = 1'b1;
                    res_d.cause     = CAUSE_ECALL;
                    res_d.exit_code = '0;
                    res_d.pass      = 1'b1;
                end else if (ev_timeout) begin
                    state_d         = RM_DONE;
                    res_d.done      = 1'b1;
                    res_d.cause     = CAUSE_TIMEOUT;
                    res_d.exit_code = '0;
                    res_d.pass      = 1'b0;
                end
            end
            RM_DONE: begin
                state_d = RM_DONE;
            end
            default: begin
                state_d = RM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RM_IDLE;
            res_q   <= RESULT_RST;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    // Both counters advance on the terminating edge too, then freeze in DONE.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (running),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_store_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (running && MemWrite),
        .count (store_count)
    );

    assign done      = res_q.done;
    assign pass      = res_q.pass;
    assign cause     = res_q.cause;
    assign exit_code = res_q.exit_code;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: two configurations share stimulus and are checked
// against a cycle-level behavioural model of the run/verdict rules.
module tb_run_monitor;

    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en;
    logic        Ecall;
    logic        Ebreak;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;

    logic        a_done, a_pass;
    logic [2:0]  a_cause;
    logic [30:0] a_exit;
    logic [31:0] a_cc, a_sc;

    logic        b_done, b_pass;
    logic [2:0]  b_cause;
    logic [30:0] b_exit;
    logic [3:0]  b_cc, b_sc;

    int n_checks = 0;
    int n_pass   = 0;

    run_monitor #(.CNT_W(32), .TIMEOUT_CYCLES(50), .TOHOST_ADDR(TOHOST)) dut_a (
        .clk(clk), .reset(reset), .en(en), .Ecall(Ecall), .Ebreak(Ebreak),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(a_done), .pass(a_pass), .cause(a_cause), .exit_code(a_exit),
        .cycle_count(a_cc), .store_count(a_sc)
    );

    run_monitor #(.CNT_W(4), .TIMEOUT_CYCLES(0), .TOHOST_ADDR(TOHOST)) dut_b (
        .clk(clk), .reset(reset), .en(en), .Ecall(Ecall), .Ebreak(Ebreak),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(b_done), .pass(b_pass), .cause(b_cause), .exit_code(b_exit),
        .cycle_count(b_cc), .store_count(b_sc)
    );

    // Reference model, index 0 = dut_a, 1 = dut_b. phase: 0 idle, 1 running, 2 finished.
    int          m_phase [2];
    logic        m_pass  [2];
    int          m_cause [2];
    logic [30:0] m_exit  [2];
    longint      m_cyc   [2];
    longint      m_st    [2];
    longint      m_max   [2] = '{64'd4294967295, 64'd15};
    longint      m_to    [2] = '{64'd50, 64'd0};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_pass[k] = 1'b0; m_cause[k] = 0;
            m_exit[k] = '0; m_cyc[k] = 0; m_st[k] = 0;
        end
    endtask

    task automatic model_clock();
        logic [30:0] code;
        bit          th;
        bit          tmo;
        code = WriteData[31:1];
        th   = MemWrite && (DataAdr == TOHOST) && WriteData[0];
        for (int k = 0; k < 2; k++) begin
            if (m_phase[k] == 0) begin
                if (en) m_phase[k] = 1;
            end else if (m_phase[k] == 1) begin
                tmo = (m_to[k] != 0) && (m_cyc[k] == m_to[k] - 1);
                if (th) begin
                    m_phase[k] = 2; m_cause[k] = 3; m_exit[k] = code; m_pass[k] = (code == 0);
                end else if (Ebreak) begin
                    m_phase[k] = 2; m_cause[k] = 2; m_pass[k] = 1'b0;
                end else if (Ecall) begin
                    m_phase[k] = 2; m_cause[k] = 1; m_pass[k] = 1'b1;
                end else if (tmo) begin
                    m_phase[k] = 2; m_cause[k] = 4; m_pass[k] = 1'b0;
                end
                m_cyc[k] = (m_cyc[k] + 1 > m_max[k]) ? m_max[k] : m_cyc[k] + 1;
                if (MemWrite) m_st[k] = (m_st[k] + 1 > m_max[k]) ? m_max[k] : m_st[k] + 1;
            end
        end
    endtask

    function automatic logic [99:0] exp_a();
        return {(m_phase[0] == 2), m_pass[0], 3'(m_cause[0]), m_exit[0], 32'(m_cyc[0]), 32'(m_st[0])};
    endfunction

    function automatic logic [43:0] exp_b();
        return {(m_phase[1] == 2), m_pass[1], 3'(m_cause[1]), m_exit[1], 4'(m_cyc[1]), 4'(m_st[1])};
    endfunction

    function automatic logic [99:0] obs_a();
        return {a_done, a_pass, a_cause, a_exit, a_cc, a_sc};
    endfunction

    function automatic logic [43:0] obs_b();
        return {b_done, b_pass, b_cause, b_exit, b_cc, b_sc};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; Ecall = 1'b0; Ebreak = 1'b0; MemWrite = 1'b0;
        DataAdr = '0; WriteData = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    task automatic start_run();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        tick();
        tick();
        n_checks++;
        if (obs_a() !== 100'd0) $display("FAIL reset_a: got %h expected 0", obs_a());
        else n_pass++;
        n_checks++;
        if (obs_b() !== 44'd0) $display("FAIL reset_b: got %h expected 0", obs_b());
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_ecall();
        start_run();
        repeat (9) tick();
        n_checks++;
        if ({a_done, a_cc} !== {1'b0, 32'd9}) $display("FAIL ecall_pre: got done=%b cc=%0d expected done=0 cc=9", a_done, a_cc);
        else n_pass++;
        Ecall = 1'b1;
        tick();
        Ecall = 1'b0;
        n_checks++;
        if ({a_done, a_pass, a_cause, a_cc} !== {1'b1, 1'b1, 3'd1, 32'd10})
            $display("FAIL ecall_done: got done=%b pass=%b cause=%0d cc=%0d expected 1 1 1 10", a_done, a_pass, a_cause, a_cc);
        else n_pass++;
        Ecall = 1'b1; en = 1'b1; MemWrite = 1'b1;
        repeat (3) tick();
        idle_inputs();
        n_checks++;
        if (obs_a() !== exp_a()) $display("FAIL ecall_hold_a: got %h expected %h", obs_a(), exp_a());
        else n_pass++;
        n_checks++;
        if (obs_b() !== exp_b()) $display("FAIL ecall_hold_b: got %h expected %h", obs_b(), exp_b());
        else n_pass++;
    endtask

    task automatic test_tohost();
        do_reset();
        start_run();
        MemWrite = 1'b1; DataAdr = TOHOST; WriteData = 32'h0000_0006;
        tick();
        n_checks++;
        if ({a_done, a_sc} !== {1'b0, 32'd1}) $display("FAIL tohost_even: got done=%b sc=%0d expected 0 1", a_done, a_sc);
        else n_pass++;
        WriteData = 32'h0000_0007;
        tick();
        idle_inputs();
        n_checks++;
        if ({a_done, a_pass, a_cause, a_exit} !== {1'b1, 1'b0, 3'd3, 31'd3})
            $display("FAIL tohost_fail: got done=%b pass=%b cause=%0d exit=%0d expected 1 0 3 3", a_done, a_pass, a_cause, a_exit);
        else n_pass++;
        n_checks++;
        if (obs_b() !== exp_b()) $display("FAIL tohost_fail_b: got %h expected %h", obs_b(), exp_b());
        else n_pass++;
        do_reset();
        start_run();
        MemWrite = 1'b1; DataAdr = TOHOST; WriteData = 32'h0000_0001;
        tick();
        idle_inputs();
        n_checks++;
        if ({a_done, a_pass, a_cause, a_exit, a_sc} !== {1'b1, 1'b1, 3'd3, 31'd0, 32'd1})
            $display("FAIL tohost_pass: got done=%b pass=%b cause=%0d exit=%0d sc=%0d expected 1 1 3 0 1", a_done, a_pass, a_cause, a_exit, a_sc);
        else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        start_run();
        Ecall = 1'b1; Ebreak = 1'b1; MemWrite = 1'b1; DataAdr = TOHOST; WriteData = 32'h0000_0001;
        tick();
        idle_inputs();
        n_checks++;
        if ({a_done, a_cause} !== {1'b1, 3'd3}) $display("FAIL prio_all: got done=%b cause=%0d expected 1 3", a_done, a_cause);
        else n_pass++;
        do_reset();
        start_run();
        Ecall = 1'b1; Ebreak = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if ({a_done, a_pass, a_cause} !== {1'b1, 1'b0, 3'd2})
            $display("FAIL prio_ebreak: got done=%b pass=%b cause=%0d expected 1 0 2", a_done, a_pass, a_cause);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        start_run();
        repeat (49) tick();
        n_checks++;
        if ({a_done, a_cc} !== {1'b0, 32'd49}) $display("FAIL timeout_pre: got done=%b cc=%0d expected 0 49", a_done, a_cc);
        else n_pass++;
        tick();
        n_checks++;
        if ({a_done, a_pass, a_cause, a_cc} !== {1'b1, 1'b0, 3'd4, 32'd50})
            $display("FAIL timeout_done: got done=%b pass=%b cause=%0d cc=%0d expected 1 0 4 50", a_done, a_pass, a_cause, a_cc);
        else n_pass++;
        Ecall = 1'b1;
        repeat (2) tick();
        Ecall = 1'b0;
        n_checks++;
        if ({a_done, a_pass, a_cause, a_cc} !== {1'b1, 1'b0, 3'd4, 32'd50})
            $display("FAIL timeout_hold: got done=%b pass=%b cause=%0d cc=%0d expected 1 0 4 50", a_done, a_pass, a_cause, a_cc);
        else n_pass++;
        n_checks++;
        if (obs_b() !== exp_b()) $display("FAIL timeout_b: got %h expected %h", obs_b(), exp_b());
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        start_run();
        MemWrite = 1'b1; DataAdr = 32'h0000_2000;
        for (int i = 0; i < 20; i++) begin
            WriteData = $urandom;
            tick();
        end
        idle_inputs();
        n_checks++;
        if ({b_done, b_cc, b_sc} !== {1'b0, 4'd15, 4'd15})
            $display("FAIL sat_b: got done=%b cc=%0d sc=%0d expected 0 15 15", b_done, b_cc, b_sc);
        else n_pass++;
        n_checks++;
        if ({a_done, a_cc, a_sc} !== {1'b0, 32'd20, 32'd20})
            $display("FAIL sat_a: got done=%b cc=%0d sc=%0d expected 0 20 20", a_done, a_cc, a_sc);
        else n_pass++;
    endtask

    task automatic test_reset_async();
        do_reset();
        start_run();
        MemWrite = 1'b1; DataAdr = 32'h0000_3000;
        repeat (5) tick();
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({obs_a(), obs_b()} !== 144'd0) $display("FAIL async_run: got a=%h b=%h expected 0", obs_a(), obs_b());
        else n_pass++;
        #1 reset = 1'b0;
        start_run();
        Ebreak = 1'b1;
        tick();
        Ebreak = 1'b0;
        n_checks++;
        if (a_done !== 1'b1) $display("FAIL async_pre_done: got done=%b expected 1", a_done);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({obs_a(), obs_b()} !== 144'd0) $display("FAIL async_done: got a=%h b=%h expected 0", obs_a(), obs_b());
        else n_pass++;
        #1 reset = 1'b0;
        Ecall = 1'b1;
        repeat (2) tick();
        Ecall = 1'b0;
        n_checks++;
        if ({a_done, a_cc} !== {1'b0, 32'd0}) $display("FAIL idle_ecall: got done=%b cc=%0d expected 0 0", a_done, a_cc);
        else n_pass++;
        start_run();
        repeat (3) tick();
        n_checks++;
        if ({a_done, a_cc} !== {1'b0, 32'd3}) $display("FAIL idle_then_run: got done=%b cc=%0d expected 0 3", a_done, a_cc);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                en       = ($urandom_range(0, 3) == 0);
                Ecall    = ($urandom_range(0, 59) == 0);
                Ebreak   = ($urandom_range(0, 79) == 0);
                MemWrite = ($urandom_range(0, 2) == 0);
                DataAdr  = ($urandom_range(0, 3) == 0) ? TOHOST : $urandom;
                WriteData = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                if ($urandom_range(0, 3) != 0) WriteData[0] = 1'b0;
                tick();
                n_checks++;
                if (obs_a() !== exp_a()) $display("FAIL random_a r%0d c%0d: got %h expected %h", r, c, obs_a(), exp_a());
                else n_pass++;
                n_checks++;
                if (obs_b() !== exp_b()) $display("FAIL random_b r%0d c%0d: got %h expected %h", r, c, obs_b(), exp_b());
                else n_pass++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_tohost();
        test_priority();
        test_timeout();
        test_saturation();
        test_reset_async();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
